// File: rtl/cmp_sweep_pkg.sv
// cmp_sweep_pkg
//   Shared definitions for the comparator exhaustive-sweep response side:
//   collector state encoding, default operand width, vector count helper and
//   the MISR single-step function.
//   No ports (package).
package cmp_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int W_DEFAULT = 3;

   // Number of vectors in a sweep of three w-bit operands.
   function automatic int unsigned n_vect(input int unsigned w);
      return 32'd1 << (32'd3 * w);
   endfunction

   // One MISR step for a signature of sig_w bits (sig_w <= 32), carried in the
   // low bits of a 32-bit word: shift left, fold the polynomial in when the
   // outgoing MSB is 1, and xor the response bit into bit 0.
   function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                             input logic [31:0] poly,
                                             input int          sig_w,
                                             input logic        din);
      logic [31:0] top_bit;
      logic [31:0] mask;
      logic        msb;
      top_bit = 32'h1 << (sig_w - 32'sd1);
      mask    = (sig_w >= 32'sd32) ? 32'hFFFF_FFFF : ((32'h1 << sig_w) - 32'h1);
      msb     = ((sig & top_bit) != 32'h0);
      return ((((sig << 1) ^ (msb ? poly : 32'h0)) & mask) ^ {31'h0, din});
   endfunction

endpackage

// File: rtl/misr_reg.sv
// misr_reg
//   Multiple-input signature register compacting a 1-bit response stream.
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   asynchronous active-high reset (loads SIG_SEED)
//     load  in   reload SIG_SEED (has priority over en)
//     en    in   compact din into the signature this cycle
//     din   in   response bit
//     q     out  current signature
import cmp_sweep_pkg::*;

module misr_reg #(
   parameter int               SIG_W    = 16,
   parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
   parameter logic [SIG_W-1:0] SIG_SEED = 16'hFFFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic             din,
   output logic [SIG_W-1:0] q
);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;

   // Next signature: seed on load, one MISR step on enable, else hold.
   always_comb begin
      sig_d = sig_q;
      if (load) begin
         sig_d = SIG_SEED;
      end else if (en) begin
         sig_d = SIG_W'(misr_step(32'(sig_q), 32'(SIG_POLY), SIG_W, din));
      end else begin
         sig_d = sig_q;
      end
   end

   // Signature register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= SIG_SEED;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign q = sig_q;

endmodule

// File: rtl/compare_resp_collector.sv
// compare_resp_collector
//   Response collector for the 3-operand comparator exhaustive sweep. Checks
//   that samples arrive in sweep order ({a,b,c} counting up, c fastest),
//   counts out=1 responses, compacts responses into a MISR and reports
//   pass/fail against golden values once the last vector has been accepted.
//   Ports:
//     clk, rst           clock, asynchronous active-high reset
//     start              pulse; begins a sweep from IDLE or DONE
//     in_valid/in_ready  sample handshake (ready is registered, 1 only in RUN)
//     in_a/in_b/in_c     operands the sample was generated from
//     in_out             comparator response for that sample
//     busy, done, pass   status (pass valid while done=1)
//     ones_cnt           accepted samples with in_out=1
//     signature          current MISR value
//     seq_err, err_idx   sticky order error and index of first bad sample
import cmp_sweep_pkg::*;

module compare_resp_collector #(
   parameter int               W           = W_DEFAULT,
   parameter int               SIG_W       = 16,
   parameter logic [SIG_W-1:0] SIG_POLY    = 16'h1021,
   parameter logic [SIG_W-1:0] SIG_SEED    = 16'hFFFF,
   parameter logic [SIG_W-1:0] GOLDEN_SIG  = 16'h0000,
   parameter int               GOLDEN_ONES = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [W-1:0]     in_c,
   input  logic             in_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [3*W:0]     ones_cnt,
   output logic [SIG_W-1:0] signature,
   output logic             seq_err,
   output logic [3*W-1:0]   err_idx
);

   localparam int IDX_W = 3 * W;
   localparam int CNT_W = IDX_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(n_vect(W) - 32'd1);
   localparam logic [CNT_W-1:0] GOLDEN_ONES_L = CNT_W'(GOLDEN_ONES);

   state_t             state_q,   state_d;
   logic [IDX_W-1:0]   idx_q,     idx_d;
   logic [CNT_W-1:0]   ones_q,    ones_d;
   logic               seq_err_q, seq_err_d;
   logic [IDX_W-1:0]   err_idx_q, err_idx_d;
   logic               done_q,    done_d;
   logic               pass_q,    pass_d;
   logic               ready_q,   ready_d;
   logic               busy_q,    busy_d;

   logic               accept_s;
   logic               last_s;
   logic               mismatch_s;
   logic               misr_load_s;
   logic [SIG_W-1:0]   sig_s;
   logic [SIG_W-1:0]   sig_next_s;

   // ready is a flop, so accept never depends combinationally on in_valid
   // reaching in_ready.
   assign accept_s   = in_valid & ready_q;
   assign last_s     = (idx_q == LAST_IDX);
   assign mismatch_s = ({in_a, in_b, in_c} != idx_q);
   // Value the MISR takes on this accept; needed so pass can be registered
   // together with done on the final edge.
   assign sig_next_s = SIG_W'(misr_step(32'(sig_s), 32'(SIG_POLY), SIG_W, in_out));

   // Next-state logic: FSM, index counter, order check, ones counter, pass.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      ones_d      = ones_q;
      seq_err_d   = seq_err_q;
      err_idx_d   = err_idx_q;
      done_d      = done_q;
      pass_d      = pass_q;
      ready_d     = ready_q;
      busy_d      = busy_q;
      misr_load_s = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_RUN;
               idx_d       = '0;
               ones_d      = '0;
               seq_err_d   = 1'b0;
               err_idx_d   = '0;
               pass_d      = 1'b0;
               done_d      = 1'b0;
               ready_d     = 1'b1;
               busy_d      = 1'b1;
               misr_load_s = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            // start is deliberately ignored here.
            if (accept_s) begin
               if (mismatch_s && !seq_err_q) begin
                  seq_err_d = 1'b1;
                  err_idx_d = idx_q;
               end else begin
                  seq_err_d = seq_err_q;
               end
               ones_d = ones_q + {{(CNT_W-1){1'b0}}, in_out};
               // Wraps to 0 on the final accept, exactly as RUN exits.
               idx_d  = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
               if (last_s) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  ready_d = 1'b0;
                  pass_d  = !seq_err_d && (sig_next_s == GOLDEN_SIG) &&
                            (ones_d == GOLDEN_ONES_L);
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            ready_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         ones_q    <= '0;
         seq_err_q <= 1'b0;
         err_idx_q <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ones_q    <= ones_d;
         seq_err_q <= seq_err_d;
         err_idx_q <= err_idx_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   misr_reg #(
      .SIG_W    (SIG_W),
      .SIG_POLY (SIG_POLY),
      .SIG_SEED (SIG_SEED)
   ) u_misr (
      .clk  (clk),
      .rst  (rst),
      .load (misr_load_s),
      .en   (accept_s),
      .din  (in_out),
      .q    (sig_s)
   );

   assign in_ready  = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign ones_cnt  = ones_q;
   assign signature = sig_s;
   assign seq_err   = seq_err_q;
   assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_compare_resp_collector.sv
// tb_compare_resp_collector
//   Directed bench for compare_resp_collector. Two instances share stimulus:
//   dut uses the default golden values, dut_g uses golden values for an
//   all-ones sweep. A bench-side model tracks the expected outputs.
module tb_compare_resp_collector;

   // Reference MISR step written directly from the signature rule.
   function automatic logic [15:0] ref_step(input logic [15:0] s, input logic d);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'h0000, d};
   endfunction

   // Final signature of a full 512-sample sweep with a constant response.
   function automatic logic [15:0] sweep_sig(input logic d);
      logic [15:0] s;
      s = 16'hFFFF;
      for (int k = 0; k < 512; k++) s = ref_step(s, d);
      return s;
   endfunction

   localparam logic [15:0] GOLD_ONES_SIG = sweep_sig(1'b1);

   logic        clk, rst, start, in_valid, in_out;
   logic [2:0]  in_a, in_b, in_c;

   logic        in_ready,   busy,   done,   pass,   seq_err;
   logic [9:0]  ones_cnt;
   logic [15:0] signature;
   logic [8:0]  err_idx;

   logic        in_ready_g, busy_g, done_g, pass_g, seq_err_g;
   logic [9:0]  ones_cnt_g;
   logic [15:0] signature_g;
   logic [8:0]  err_idx_g;

   compare_resp_collector dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_out(in_out),
      .busy(busy), .done(done), .pass(pass), .ones_cnt(ones_cnt),
      .signature(signature), .seq_err(seq_err), .err_idx(err_idx)
   );

   compare_resp_collector #(
      .GOLDEN_SIG  (GOLD_ONES_SIG),
      .GOLDEN_ONES (512)
   ) dut_g (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_g),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_out(in_out),
      .busy(busy_g), .done(done_g), .pass(pass_g), .ones_cnt(ones_cnt_g),
      .signature(signature_g), .seq_err(seq_err_g), .err_idx(err_idx_g)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   bit          m_run, m_done, m_err, m_pass, m_pass_g;
   int          m_cnt, m_ones, m_err_idx;
   logic [15:0] m_sig;

   task automatic model_reset();
      m_run = 1'b0; m_done = 1'b0; m_err = 1'b0; m_pass = 1'b0; m_pass_g = 1'b0;
      m_cnt = 0; m_ones = 0; m_err_idx = 0; m_sig = 16'hFFFF;
   endtask

   // Apply the effect of one rising clock edge, given the inputs at that edge.
   task automatic model_edge();
      logic [8:0] want;
      if (rst) begin
         model_reset();
      end else if (m_run) begin
         if (in_valid) begin
            want = m_cnt[8:0];
            if ({in_a, in_b, in_c} != want && !m_err) begin
               m_err = 1'b1;
               m_err_idx = m_cnt;
            end
            m_ones = m_ones + int'(in_out);
            m_sig  = ref_step(m_sig, in_out);
            m_cnt++;
            if (m_cnt == 512) begin
               m_run    = 1'b0;
               m_done   = 1'b1;
               m_pass   = !m_err && m_sig == 16'h0000 && m_ones == 0;
               m_pass_g = !m_err && m_sig == GOLD_ONES_SIG && m_ones == 512;
               m_cnt    = 0;
            end
         end
      end else if (start) begin
         m_run = 1'b1; m_done = 1'b0; m_err = 1'b0; m_pass = 1'b0; m_pass_g = 1'b0;
         m_cnt = 0; m_ones = 0; m_err_idx = 0; m_sig = 16'hFFFF;
      end
   endtask

   // Compare process: every output of both instances, every cycle.
   always @(negedge clk) begin
      chk("in_ready",    32'(in_ready),    32'(m_run));
      chk("busy",        32'(busy),        32'(m_run));
      chk("done",        32'(done),        32'(m_done));
      chk("pass",        32'(pass),        32'(m_pass));
      chk("ones_cnt",    32'(ones_cnt),    32'(m_ones));
      chk("signature",   32'(signature),   32'(m_sig));
      chk("seq_err",     32'(seq_err),     32'(m_err));
      chk("err_idx",     32'(err_idx),     32'(m_err_idx));
      chk("g_in_ready",  32'(in_ready_g),  32'(m_run));
      chk("g_busy",      32'(busy_g),      32'(m_run));
      chk("g_done",      32'(done_g),      32'(m_done));
      chk("g_pass",      32'(pass_g),      32'(m_pass_g));
      chk("g_ones_cnt",  32'(ones_cnt_g),  32'(m_ones));
      chk("g_signature", 32'(signature_g), 32'(m_sig));
      chk("g_seq_err",   32'(seq_err_g),   32'(m_err));
      chk("g_err_idx",   32'(err_idx_g),   32'(m_err_idx));
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic v, input logic [8:0] abc, input logic o, input logic st);
      in_valid = v;
      {in_a, in_b, in_c} = abc;
      in_out = o;
      start = st;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Mid-cycle reset (called at posedge+1, asserts before the next negedge).
   task automatic do_reset();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_ones_async", 32'(ones_cnt), 32'd0);
      chk("rst_busy_async", 32'(busy), 32'd0);
      chk("rst_sig_async", 32'(signature), 32'h0000FFFF);
      cyc(1'b0, 9'h000, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   // One full sweep: start, then 512 samples. bad: index sent as idx+1 (c off
   // by one); gaps: idle cycle before each sample; xstart: sample index at
   // which start is also pulsed.
   task automatic sweep(input logic o, input int bad, input bit gaps, input int xstart,
                        input bit do_pin, input logic [15:0] pin);
      logic [8:0] abc;
      cyc(1'b0, 9'h000, 1'b0, 1'b1);
      chk("start_clears_ones", 32'(ones_cnt), 32'd0);
      chk("start_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 512; i++) begin
         abc = 9'(i);
         if (i == bad) abc = 9'(i + 1);
         if (gaps) cyc(1'b0, 9'h1AB, 1'b1, 1'b0);
         cyc(1'b1, abc, o, (i == xstart) ? 1'b1 : 1'b0);
         if (do_pin && i == 0) chk("first_sig", 32'(signature), 32'(pin));
         if (i == 510) chk("not_done_before_last", 32'(done), 32'd0);
      end
      chk("done_on_last_accept", 32'(done), 32'd1);
      chk("busy_off_on_last", 32'(busy), 32'd0);
   endtask

   logic [15:0] sig_ref2;

   initial begin
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_out = 1'b0;
      in_a = 3'd0; in_b = 3'd0; in_c = 3'd0;

      // 1: reset before any clock edge
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_ones", 32'(ones_cnt), 32'd0);
      chk("rst_sig", 32'(signature), 32'h0000FFFF);
      chk("rst_seq_err", 32'(seq_err), 32'd0);
      chk("rst_err_idx", 32'(err_idx), 32'd0);
      cyc(1'b0, 9'h000, 1'b0, 1'b0);
      rst = 1'b0;
      cyc(1'b1, 9'h000, 1'b1, 1'b0);   // valid in IDLE is ignored

      // 2: ordered sweep, all responses 0
      sweep(1'b0, -1, 1'b0, -1, 1'b1, 16'hEFDF);
      chk("s2_ones", 32'(ones_cnt), 32'd0);
      chk("s2_seq_err", 32'(seq_err), 32'd0);
      chk("s2_sig_model", 32'(signature), 32'(sweep_sig(1'b0)));
      sig_ref2 = m_sig;
      for (int k = 0; k < 3; k++) cyc(1'b1, 9'h000, 1'b1, 1'b0);   // ignored in DONE
      chk("s2_done_held", 32'(done), 32'd1);

      // 3: all responses 1; dut_g's goldens match this sweep
      sweep(1'b1, -1, 1'b0, -1, 1'b1, 16'hEFDE);
      chk("s3_ones", 32'(ones_cnt), 32'd512);
      chk("s3_pass_g", 32'(pass_g), 32'd1);
      chk("s3_pass_default", 32'(pass), 32'd0);

      // 4: sample 37 out of order
      sweep(1'b0, 37, 1'b0, -1, 1'b0, 16'h0000);
      chk("s4_seq_err", 32'(seq_err), 32'd1);
      chk("s4_err_idx", 32'(err_idx), 32'd37);
      chk("s4_pass", 32'(pass), 32'd0);

      // 5: valid every other cycle plus a start pulse during RUN
      sweep(1'b0, -1, 1'b1, 200, 1'b0, 16'h0000);
      chk("s5_sig_same_as_s2", 32'(signature), 32'(sig_ref2));
      chk("s5_ones", 32'(ones_cnt), 32'd0);
      chk("s5_seq_err_cleared", 32'(seq_err), 32'd0);

      // 6: reset after 100 accepts, then full sweeps from IDLE and from DONE
      cyc(1'b0, 9'h000, 1'b0, 1'b1);
      for (int i = 0; i < 100; i++) cyc(1'b1, 9'(i), 1'b1, 1'b0);
      chk("s6_ones_100", 32'(ones_cnt), 32'd100);
      do_reset();
      chk("s6_ones_after_rst", 32'(ones_cnt), 32'd0);
      chk("s6_ready_after_rst", 32'(in_ready), 32'd0);
      sweep(1'b1, -1, 1'b0, -1, 1'b0, 16'h0000);
      chk("s6_pass_g", 32'(pass_g), 32'd1);
      sweep(1'b0, 5, 1'b0, -1, 1'b0, 16'h0000);
      chk("s6_rerun_err_idx", 32'(err_idx), 32'd5);
      cyc(1'b0, 9'h000, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
